// File: rtl/aibcr3aux_pwrgood_seq.sv
// rtl/aibcr3aux_pwrgood_seq.sv - power-good synchronizer, debouncer and staged aux/core reset release
module aibcr3aux_pwrgood_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 16,
    parameter int STAGE_DLY   = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pwrgood_ls,
    input  logic       i_sw_rst,
    output logic       o_aux_rstb,
    output logic       o_core_rstb,
    output logic       o_pwr_good,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        DEBOUNCE = 2'd1,
        AUX_UP   = 2'd2,
        ACTIVE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;

    assign s       = sync[SYNC_STAGES-1];
    assign o_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_pwrgood_ls};
        end
    end

    // Any non-advancing path clears the counter, so a partial debounce is never kept.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        if (i_sw_rst) begin
            state_n = OFF;
        end else begin
            unique case (state)
                OFF: begin
                    if (s) state_n = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!s)                   state_n = OFF;
                    else if (cnt == DEB_LAST) state_n = AUX_UP;
                    else                      cnt_n   = cnt + CNT_W'(1);
                end
                AUX_UP: begin
                    if (!s)                     state_n = OFF;
                    else if (cnt == STAGE_LAST) state_n = ACTIVE;
                    else                        cnt_n   = cnt + CNT_W'(1);
                end
                ACTIVE: begin
                    if (!s) state_n = OFF;
                end
                default: state_n = OFF;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OFF;
            cnt         <= '0;
            o_aux_rstb  <= 1'b0;
            o_core_rstb <= 1'b0;
            o_pwr_good  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            o_aux_rstb  <= (state_n == AUX_UP) || (state_n == ACTIVE);
            o_core_rstb <= (state_n == ACTIVE);
            o_pwr_good  <= (state_n == ACTIVE);
        end
    end

endmodule

// File: tb/tb_aibcr3aux_pwrgood_seq.sv
// tb/tb_aibcr3aux_pwrgood_seq.sv - randomized bench for aibcr3aux_pwrgood_seq against a run-length reference model
module tb_aibcr3aux_pwrgood_seq;

    localparam int SYNC  = 2;
    localparam int DEB   = 16;
    localparam int STG   = 8;
    localparam int DEB_B = 1;
    localparam int STG_B = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pg  = 1'b0;
    logic       sw  = 1'b0;
    logic       a_aux, a_core, a_pg, b_aux, b_core, b_pg;
    logic [1:0] a_state, b_state;

    int checks = 0;
    int errors = 0;
    int run    = 0;
    int edge_n = 0;
    logic [SYNC-1:0] sh = '0;

    always #5 clk = ~clk;

    aibcr3aux_pwrgood_seq #(.SYNC_STAGES(SYNC), .DEB_CNT(DEB), .STAGE_DLY(STG), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .i_pwrgood_ls(pg), .i_sw_rst(sw),
        .o_aux_rstb(a_aux), .o_core_rstb(a_core), .o_pwr_good(a_pg), .o_state(a_state)
    );

    aibcr3aux_pwrgood_seq #(.SYNC_STAGES(SYNC), .DEB_CNT(DEB_B), .STAGE_DLY(STG_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .i_pwrgood_ls(pg), .i_sw_rst(sw),
        .o_aux_rstb(b_aux), .o_core_rstb(b_core), .o_pwr_good(b_pg), .o_state(b_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    // run = consecutive edges that sampled s=1 without a software reset
    function automatic int exp_state(input int r, input int d, input int g);
        if (r == 0)     return 0;
        if (r <= d)     return 1;
        if (r <= d + g) return 2;
        return 3;
    endfunction

    task automatic check_all();
        int ea, eb;
        ea = exp_state(run, DEB, STG);
        eb = exp_state(run, DEB_B, STG_B);
        check("a_state", int'(a_state), ea);
        check("a_aux",   int'(a_aux),   int'(ea >= 2));
        check("a_core",  int'(a_core),  int'(ea == 3));
        check("a_pg",    int'(a_pg),    int'(ea == 3));
        check("b_state", int'(b_state), eb);
        check("b_aux",   int'(b_aux),   int'(eb >= 2));
        check("b_core",  int'(b_core),  int'(eb == 3));
        check("b_pg",    int'(b_pg),    int'(eb == 3));
    endtask

    task automatic cycle(input logic p, input logic w);
        pg = p;
        sw = w;
        @(posedge clk);
        edge_n++;
        if (sh[SYNC-1] && !w) run++;
        else                  run = 0;
        sh = {sh[SYNC-2:0], p};
        #1 check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        run = 0;
        sh  = '0;
        check_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        int a_aux_e = 0, a_core_e = 0, b_deb_e = 0, b_aux_e = 0, b_core_e = 0;
        #1 check_all();
        #11 rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b0);
            if (a_aux  && a_aux_e  == 0) a_aux_e  = edge_n;
            if (a_core && a_core_e == 0) a_core_e = edge_n;
            if (b_state == 2'd1 && b_deb_e == 0) b_deb_e = edge_n;
            if (b_aux  && b_aux_e  == 0) b_aux_e  = edge_n;
            if (b_core && b_core_e == 0) b_core_e = edge_n;
        end
        check("pu_a_aux_edge",  a_aux_e,  19);
        check("pu_a_core_edge", a_core_e, 27);
        check("pu_b_deb_edge",  b_deb_e,  3);
        check("pu_b_aux_edge",  b_aux_e,  4);
        check("pu_b_core_edge", b_core_e, 5);

        for (int i = 0; i < 5;  i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 5;  i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 21; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 4;  i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
        async_reset();

        for (int seg = 0; seg < 80; seg++) begin
            int   len;
            logic p;
            len = $urandom_range(1, 32);
            p   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++)
                cycle(p, ($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 9) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
